alu_mc: RTL

ALU_MC -- requirements
Module: alu_mc

---
 rtl/alu_pkg.sv | 36 +++
 rtl/alu_iter_unit.sv | 102 ++++++++++
 rtl/alu_mc.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM state type and opcode classification helpers
// for the multi-cycle ALU.
package alu_pkg;

  localparam logic [4:0] OP_ADD = 5'h00;
  localparam logic [4:0] OP_SUB = 5'h01;
  localparam logic [4:0] OP_MUL = 5'h02;
  localparam logic [4:0] OP_DIV = 5'h03;
  localparam logic [4:0] OP_MOD = 5'h04;
  localparam logic [4:0] OP_CMP = 5'h05;
  localparam logic [4:0] OP_AND = 5'h06;
  localparam logic [4:0] OP_OR  = 5'h07;
  localparam logic [4:0] OP_NOT = 5'h08;
  localparam logic [4:0] OP_MOV = 5'h09;
  localparam logic [4:0] OP_LSL = 5'h0A;
  localparam logic [4:0] OP_LSR = 5'h0B;
  localparam logic [4:0] OP_ASR = 5'h0C;
  localparam logic [4:0] OP_NOP = 5'h0D;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Opcodes that need the iterative mul/div datapath
  function automatic logic is_iter_op(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
  endfunction

  // Opcodes that produce a quotient or remainder
  function automatic logic is_div_op(input logic [4:0] op);
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/alu_iter_unit.sv
// Iterative datapath: shift-add multiply (low WIDTH bits of the product) and
// unsigned restoring division, one step per clock, WIDTH steps per operation.
// o_done pulses for one cycle after the final step.
module alu_iter_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_op_div,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_done,
  output logic [WIDTH-1:0] o_product,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  // r_acc: product accumulator / partial remainder
  // r_opa: shifted multiplicand / dividend-becoming-quotient
  // r_opb: shifted multiplier / divisor
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_div;
  logic             r_done;

  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_acc_nxt;
  logic [WIDTH-1:0] w_opa_nxt;
  logic [WIDTH-1:0] w_opb_nxt;

  // Next-step values for one multiply or restoring-divide iteration
  always_comb begin
    w_rem_sh = {r_acc, r_opa[WIDTH-1]};
    w_diff   = w_rem_sh - {1'b0, r_opb};
    if (r_div) begin
      if (!w_diff[WIDTH]) begin
        w_acc_nxt = w_diff[WIDTH-1:0];
        w_opa_nxt = {r_opa[WIDTH-2:0], 1'b1};
      end else begin
        w_acc_nxt = w_rem_sh[WIDTH-1:0];
        w_opa_nxt = {r_opa[WIDTH-2:0], 1'b0};
      end
      w_opb_nxt = r_opb;
    end else begin
      if (r_opb[0]) begin
        w_acc_nxt = r_acc + r_opa;
      end else begin
        w_acc_nxt = r_acc;
      end
      w_opa_nxt = {r_opa[WIDTH-2:0], 1'b0};
      w_opb_nxt = {1'b0, r_opb[WIDTH-1:1]};
    end
  end

  // Load operands on start, then step until the iteration count is exhausted
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc  <= {WIDTH{1'b0}};
      r_opa  <= {WIDTH{1'b0}};
      r_opb  <= {WIDTH{1'b0}};
      r_cnt  <= {CW{1'b0}};
      r_busy <= 1'b0;
      r_div  <= 1'b0;
      r_done <= 1'b0;
    end else if (i_start) begin
      r_acc  <= {WIDTH{1'b0}};
      r_opa  <= i_a;
      r_opb  <= i_b;
      r_cnt  <= {CW{1'b0}};
      r_busy <= 1'b1;
      r_div  <= i_op_div;
      r_done <= 1'b0;
    end else if (r_busy) begin
      r_acc <= w_acc_nxt;
      r_opa <= w_opa_nxt;
      r_opb <= w_opb_nxt;
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == CNT_LAST) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end else begin
        r_done <= 1'b0;
      end
    end else begin
      r_done <= 1'b0;
    end
  end

  assign o_done      = r_done;
  assign o_product   = r_acc;
  assign o_quotient  = r_opa;
  assign o_remainder = r_acc;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes. One operation outstanding:
// IDLE accepts, BUSY computes (one cycle, or WIDTH+1 for mul/div/mod),
// DONE holds the result until the consumer takes it.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       alusignal,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic [1:0]       flags,
  output logic             err
);

  state_t           r_state;
  logic [4:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [1:0]       r_flags;
  logic             r_err;
  logic             r_out_valid;

  logic             w_start;
  logic             w_b_zero;
  logic             w_big;
  logic [SHW-1:0]   w_shamt;
  logic             w_use_iter;
  logic             w_iter_done;
  logic [WIDTH-1:0] w_product;
  logic [WIDTH-1:0] w_quotient;
  logic [WIDTH-1:0] w_remainder;
  logic [WIDTH-1:0] w_iter_res;
  logic [WIDTH-1:0] w_res;
  logic             w_err;
  logic             w_flags_upd;
  logic [1:0]       w_flags;

  assign in_ready = (r_state == ST_IDLE) && !rst;

  // A zero divisor never enters the iterative unit; it completes in one cycle
  assign w_start = in_valid && in_ready && is_iter_op(alusignal) &&
                   !(is_div_op(alusignal) && (b == {WIDTH{1'b0}}));

  assign w_b_zero   = (r_b == {WIDTH{1'b0}});
  assign w_big      = |(r_b >> SHW);
  assign w_shamt    = r_b[SHW-1:0];
  assign w_use_iter = is_iter_op(r_op) && !(is_div_op(r_op) && w_b_zero);

  alu_iter_unit #(.WIDTH(WIDTH)) u_iter (
    .clk         (clk),
    .rst         (rst),
    .i_start     (w_start),
    .i_op_div    (is_div_op(alusignal)),
    .i_a         (a),
    .i_b         (b),
    .o_done      (w_iter_done),
    .o_product   (w_product),
    .o_quotient  (w_quotient),
    .o_remainder (w_remainder)
  );

  // Select the iterative result matching the captured opcode
  always_comb begin
    if (r_op == OP_MUL) begin
      w_iter_res = w_product;
    end else if (r_op == OP_DIV) begin
      w_iter_res = w_quotient;
    end else begin
      w_iter_res = w_remainder;
    end
  end

  // Single-cycle result, error and flag update from the captured operands
  always_comb begin
    w_res       = {WIDTH{1'b0}};
    w_err       = 1'b0;
    w_flags_upd = 1'b0;
    w_flags     = 2'b00;
    case (r_op)
      OP_ADD: w_res = r_a + r_b;
      OP_SUB: w_res = r_a - r_b;
      OP_MUL: w_res = {WIDTH{1'b0}};
      OP_DIV: begin
        w_res = {WIDTH{1'b1}};
        w_err = 1'b1;
      end
      OP_MOD: begin
        w_res = r_a;
        w_err = 1'b1;
      end
      OP_CMP: begin
        w_flags_upd = 1'b1;
        if ($signed(r_a) == $signed(r_b)) begin
          w_flags = 2'b01;
        end else if ($signed(r_a) > $signed(r_b)) begin
          w_flags = 2'b10;
        end else begin
          w_flags = 2'b00;
        end
      end
      OP_AND: w_res = r_a & r_b;
      OP_OR:  w_res = r_a | r_b;
      OP_NOT: w_res = ~r_a;
      OP_MOV: w_res = r_b;
      OP_LSL: begin
        if (w_big) w_res = {WIDTH{1'b0}};
        else       w_res = r_a << w_shamt;
      end
      OP_LSR: begin
        if (w_big) w_res = {WIDTH{1'b0}};
        else       w_res = r_a >> w_shamt;
      end
      OP_ASR: begin
        if (w_big) w_res = {WIDTH{r_a[WIDTH-1]}};
        else       w_res = $unsigned($signed(r_a) >>> w_shamt);
      end
      OP_NOP: w_res = {WIDTH{1'b0}};
      default: begin
        w_err       = 1'b1;
        w_flags_upd = 1'b1;
        w_flags     = 2'b00;
      end
    endcase
  end

  // Control FSM with registered result, flags, error and out_valid
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_op        <= 5'h00;
      r_a         <= {WIDTH{1'b0}};
      r_b         <= {WIDTH{1'b0}};
      r_res       <= {WIDTH{1'b0}};
      r_flags     <= 2'b00;
      r_err       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_op    <= alusignal;
            r_a     <= a;
            r_b     <= b;
            r_state <= ST_BUSY;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (w_use_iter) begin
            if (w_iter_done) begin
              r_res       <= w_iter_res;
              r_err       <= 1'b0;
              r_out_valid <= 1'b1;
              r_state     <= ST_DONE;
            end else begin
              r_state <= ST_BUSY;
            end
          end else begin
            r_res       <= w_res;
            r_err       <= w_err;
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
            if (w_flags_upd) begin
              r_flags <= w_flags;
            end else begin
              r_flags <= r_flags;
            end
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end else begin
            r_state <= ST_DONE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign res       = r_res;
  assign flags     = r_flags;
  assign err       = r_err;

endmodule
